datapath_controller: RTL and testbench
======================================

Name: datapath_controller

Overview:
- Moore FSM that sequences the 8x16 register file and datapath for one instruction per start pulse.
- Drives the register file read/write selects (nsel), the write strobe, and the A/B/C/status load enables, operand selects and writeback mux select.
- Sits between the instruction register and the datapath. Instruction register fields {opcode, op} are inputs; the datapath's ALU op code bypasses this block.

Parameters:
- ILLEGAL_TRAP, 0: 0 = an illegal {opcode,op} returns to WAIT with no side effects; 1 = it enters HALT, asserts err, and stays until reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in WAIT
- opcode  in  3  instruction opcode field
- op  in  2  instruction op field
- w  out  1  1 = idle in WAIT, ready for s
- err  out  1  illegal instruction trapped (ILLEGAL_TRAP=1 only)
- nsel  out  3  one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none
- write  out  1  register file write strobe
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status register
- asel  out  1  1 = force ALU A input to 0
- bsel  out  1  1 = ALU B input from sximm5 (always 0 in this block)
- vsel  out  2  writeback select: 00 = C, 10 = sximm8; 01 and 11 are never driven

Behaviour:
- Reset:
  - reset_n low forces state WAIT immediately, regardless of clock.
  - w=1, err=0; all strobes, nsel, asel, bsel and vsel are 0.
  - Reset asserted mid-sequence aborts it; no further strobes are driven.
- Output timing: all outputs decode from the current state only (Moore). No output depends combinationally on s, opcode or op.
- Field capture: on WAIT with s=1, {opcode,op} is latched into an internal register. All later decisions use the latched copy, so instruction-input changes mid-sequence have no effect.
- States and transitions:
  - WAIT: w=1. If s=1, go to DECODE; else stay.
  - DECODE: no strobes. Branch on the latched fields:
    - 110_10 (MOV Rn,#imm8) -> WIMM
    - 110_00 (MOV Rd,Rm) -> GETB
    - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) -> GETA
    - 101_11 (MVN) -> GETB
    - anything else -> WAIT if ILLEGAL_TRAP=0, HALT if ILLEGAL_TRAP=1
  - GETA: nsel=001, loada=1 -> GETB.
  - GETB: nsel=100, loadb=1 -> ALU.
  - ALU:
    - asel=1 for MOV Rd,Rm, else 0; bsel=0.
    - CMP: loads=1, loadc=0, then -> WAIT.
    - Others: loadc=1, then -> WREG.
  - WREG: nsel=010, vsel=00, write=1 -> WAIT.
  - WIMM: nsel=001, vsel=10, write=1 -> WAIT.
  - HALT: err=1, w=0, all strobes 0. Exit only via reset.
- Strobe rules:
  - At most one load/write strobe group is active per cycle.
  - write is never asserted in the same cycle as loada or loadb.
- Latency, counted in cycles from the edge that samples s=1 until w is high again:
  - MOV imm: 3 (DECODE, WIMM, WAIT)
  - MOV reg and MVN: 5
  - ADD and AND: 6
  - CMP: 5
  - Illegal with ILLEGAL_TRAP=0: 2
- Back-to-back: if s is held high, the next instruction is captured on the first WAIT cycle. There is no dead cycle beyond WAIT itself.
- s is ignored in every state except WAIT.

Test Plan:
- Reset: hold reset_n=0 with s=1 -> w=1, err=0, all strobes 0; w stays 1 until s is sampled after release.
- MOV R3,#7 (opcode=110, op=10):
  - Pulse s for 1 cycle -> DECODE, then WIMM with nsel=001, vsel=10, write=1 for exactly 1 cycle.
  - w returns high 3 cycles after s was sampled.
- ADD (101_00):
  - s pulse -> loada (nsel=001), then loadb (nsel=100), then loadc with asel=0, then write (nsel=010, vsel=00), each for 1 cycle.
  - w high on cycle 6.
  - Change opcode to 110 during GETA -> sequence unchanged.
- CMP (101_01) -> loads=1 in the ALU cycle, no loadc and no write; w high on cycle 5.
- MOV Rd,Rm, then MVN back-to-back with s held high:
  - MOV: ALU cycle has asel=1.
  - MVN: ALU cycle has asel=0 and starts with no idle cycle beyond WAIT.
- Illegal {111,00}:
  - ILLEGAL_TRAP=0 -> w high after 2 cycles, no strobes.
  - ILLEGAL_TRAP=1 -> err=1 persists for 20+ cycles; reset_n pulse clears it.
  - reset_n asserted during an ADD in GETB -> immediate WAIT, loadb drops the same cycle.

Source files
------------

// File: rtl/datapath_controller.sv
// Moore sequencer for the 8x16 register file and datapath.
// It runs one instruction, latched from {opcode, op}, for each start pulse.
module datapath_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic       err,
    output logic [2:0] nsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GETA,
        ST_GETB,
        ST_ALU,
        ST_WREG,
        ST_WIMM,
        ST_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] instr;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_mvn;
    logic is_cmp;
    logic is_alu_ab;

    assign is_mov_imm = (instr == 5'b110_10);
    assign is_mov_reg = (instr == 5'b110_00);
    assign is_mvn     = (instr == 5'b101_11);
    assign is_cmp     = (instr == 5'b101_01);
    assign is_alu_ab  = (instr == 5'b101_00) || is_cmp || (instr == 5'b101_10);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Instruction fields are captured only on the start sample, so later input changes cannot steer the sequence.
    always_ff @(posedge clk) begin
        if (state == ST_WAIT && s) begin
            instr <= {opcode, op};
        end
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        err        = 1'b0;
        nsel       = 3'b000;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 2'b00;
        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_mov_imm)                 state_next = ST_WIMM;
                else if (is_mov_reg || is_mvn)  state_next = ST_GETB;
                else if (is_alu_ab)             state_next = ST_GETA;
                else if (ILLEGAL_TRAP)          state_next = ST_HALT;
                else                            state_next = ST_WAIT;
            end
            ST_GETA: begin
                nsel       = 3'b001;
                loada      = 1'b1;
                state_next = ST_GETB;
            end
            ST_GETB: begin
                nsel       = 3'b100;
                loadb      = 1'b1;
                state_next = ST_ALU;
            end
            ST_ALU: begin
                // MOV Rd,Rm passes B through the ALU by zeroing the A operand.
                asel = is_mov_reg;
                if (is_cmp) begin
                    loads      = 1'b1;
                    state_next = ST_WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = ST_WREG;
                end
            end
            ST_WREG: begin
                nsel       = 3'b010;
                vsel       = 2'b00;
                write      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WIMM: begin
                nsel       = 3'b001;
                vsel       = 2'b10;
                write      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_HALT: begin
                err = 1'b1;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: a non-trapping and a trapping instance share stimulus.
// A per-instruction output script model is compared every cycle, and directed literal checks are added.
module tb_datapath_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;

    logic       w0, err0, write0, loada0, loadb0, loadc0, loads0, asel0, bsel0;
    logic [2:0] nsel0;
    logic [1:0] vsel0;
    logic       w1, err1, write1, loada1, loadb1, loadc1, loads1, asel1, bsel1;
    logic [2:0] nsel1;
    logic [1:0] vsel1;

    int vectors = 0;
    int miscompares = 0;

    datapath_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w0), .err(err0), .nsel(nsel0), .write(write0), .loada(loada0),
        .loadb(loadb0), .loadc(loadc0), .loads(loads0), .asel(asel0),
        .bsel(bsel0), .vsel(vsel0)
    );

    datapath_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w1), .err(err1), .nsel(nsel1), .write(write1), .loada(loada1),
        .loadb(loadb1), .loadc(loadc1), .loads(loads1), .asel(asel1),
        .bsel(bsel1), .vsel(vsel1)
    );

    always #5 clk = ~clk;

    // Output vector layout: {w, err, nsel[2:0], write, loada, loadb, loadc, loads, asel, bsel, vsel[1:0]}
    logic [13:0] o0, o1;
    assign o0 = {w0, err0, nsel0, write0, loada0, loadb0, loadc0, loads0, asel0, bsel0, vsel0};
    assign o1 = {w1, err1, nsel1, write1, loada1, loadb1, loadc1, loads1, asel1, bsel1, vsel1};

    localparam logic [13:0] IDLE = 14'h2000;
    localparam logic [13:0] HALT = 14'h1000;

    function automatic logic [13:0] mk(input logic [2:0] nsel, input bit wr, input bit la,
                                       input bit lb, input bit lc, input bit ls,
                                       input bit as, input logic [1:0] vs);
        return {1'b0, 1'b0, nsel, wr, la, lb, lc, ls, as, 1'b0, vs};
    endfunction

    // The expected non-WAIT cycles of one instruction, written straight from the instruction table.
    task automatic plan(input logic [2:0] opc, input logic [1:0] o, input bit trap,
                        output logic [13:0] seq [5], output int n);
        logic [13:0] dec, geta, getb, wreg, wimm;
        dec  = 14'h0000;
        geta = mk(3'b001, 0, 1, 0, 0, 0, 0, 2'b00);
        getb = mk(3'b100, 0, 0, 1, 0, 0, 0, 2'b00);
        wreg = mk(3'b010, 1, 0, 0, 0, 0, 0, 2'b00);
        wimm = mk(3'b001, 1, 0, 0, 0, 0, 0, 2'b10);
        for (int i = 0; i < 5; i++) seq[i] = 14'h0000;
        seq[0] = dec;
        if (opc == 3'b110 && o == 2'b10) begin
            seq[1] = wimm; n = 2;
        end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
            seq[1] = getb;
            seq[2] = mk(3'b000, 0, 0, 0, 1, 0, (opc == 3'b110), 2'b00);
            seq[3] = wreg; n = 4;
        end else if (opc == 3'b101 && o == 2'b01) begin
            seq[1] = geta; seq[2] = getb;
            seq[3] = mk(3'b000, 0, 0, 0, 0, 1, 0, 2'b00); n = 4;
        end else if (opc == 3'b101) begin
            seq[1] = geta; seq[2] = getb;
            seq[3] = mk(3'b000, 0, 0, 0, 1, 0, 0, 2'b00);
            seq[4] = wreg; n = 5;
        end else if (trap) begin
            seq[1] = HALT; n = 2;
        end else begin
            n = 1;
        end
    endtask

    logic [13:0] q0[$];
    logic [13:0] q1[$];

    always @(posedge clk or negedge reset_n) begin
        logic [13:0] sq [5];
        int n;
        if (!reset_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() > 0) begin
                void'(q0.pop_front());
            end else if (s) begin
                plan(opcode, op, 1'b0, sq, n);
                for (int i = 0; i < n; i++) q0.push_back(sq[i]);
            end
            if (q1.size() > 0) begin
                if (!(q1.size() == 1 && q1[0] == HALT)) void'(q1.pop_front());
            end else if (s) begin
                plan(opcode, op, 1'b1, sq, n);
                for (int i = 0; i < n; i++) q1.push_back(sq[i]);
            end
        end
    end

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [13:0] e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : IDLE;
        e1 = (q1.size() > 0) ? q1[0] : IDLE;
        check("dut0_cycle", o0, e0);
        check("dut1_cycle", o1, e1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction and measures cycles from the start sample until w0 is high again.
    task automatic run(input logic [2:0] opc, input logic [1:0] o, input int exp_lat, input string name);
        int c;
        step();
        s = 1'b1; opcode = opc; op = o;
        step();
        s = 1'b0;
        c = 1;
        while (!w0 && c < 30) begin
            step();
            c++;
        end
        check(name, 14'(c), 14'(exp_lat));
    endtask

    initial begin
        // Reset held with s high.
        s = 1'b1; opcode = 3'b110; op = 2'b10;
        repeat (3) step();
        check("reset_outputs0", o0, IDLE);
        check("reset_outputs1", o1, IDLE);
        s = 1'b0; reset_n = 1'b1;
        step(); step();
        check("idle_after_release", 14'(w0), 14'(1));

        // MOV R3,#7 with literal per-cycle checks.
        step();
        s = 1'b1; opcode = 3'b110; op = 2'b10;
        step();
        s = 1'b0;
        check("movi_decode", o0, 14'h0000);
        step();
        check("movi_wimm", o0, 14'b0_0_001_1_0000_0_0_10);
        step();
        check("movi_back_to_wait", 14'(w0), 14'(1));

        // ADD with opcode changed during GETA.
        step();
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        step();
        s = 1'b0;
        step();
        check("add_geta", o0, 14'b0_0_001_0_1000_0_0_00);
        opcode = 3'b110;
        step();
        check("add_getb", o0, 14'b0_0_100_0_0100_0_0_00);
        step();
        check("add_alu", o0, 14'b0_0_000_0_0010_0_0_00);
        step();
        check("add_wreg", o0, 14'b0_0_010_1_0000_0_0_00);
        step();
        check("add_lat6", 14'(w0), 14'(1));

        run(3'b101, 2'b01, 5, "cmp_lat");
        run(3'b101, 2'b10, 6, "and_lat");
        run(3'b110, 2'b10, 3, "movi_lat");
        run(3'b101, 2'b11, 5, "mvn_lat");

        // MOV Rd,Rm then MVN back-to-back with s held high.
        step();
        s = 1'b1; opcode = 3'b110; op = 2'b00;
        step();
        opcode = 3'b101; op = 2'b11;
        step();
        step();
        check("movr_alu_asel", {asel0, loadc0}, 14'b11);
        step();
        step();
        check("b2b_wait", 14'(w0), 14'(1));
        step();
        check("b2b_no_idle", 14'(w0), 14'(0));
        s = 1'b0;
        step();
        step();
        check("mvn_alu_asel", {asel0, loadc0}, 14'b01);
        step();
        step();
        check("mvn_done", 14'(w0), 14'(1));

        // Illegal instruction: dut0 returns, dut1 traps.
        run(3'b111, 2'b00, 2, "illegal_lat");
        repeat (25) step();
        check("trap_persist", {w1, err1}, 14'b01);
        reset_n = 1'b0;
        #1;
        check("trap_cleared", {w1, err1}, 14'b10);
        step();
        reset_n = 1'b1;
        step();

        // Reset during ADD in GETB.
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        step();
        s = 1'b0;
        step();
        step();
        check("abort_getb_before", 14'(loadb0), 14'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_getb_drop", o0, IDLE);
        step();
        reset_n = 1'b1;
        step(); step();
        check("abort_stays_idle", o0, IDLE);

        run(3'b100, 2'b10, 2, "illegal2_lat");
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
